// File: rtl/cvxif_vec_exec_pkg.sv
// Shared types and sizing for the CV-X-IF vector execution stage.
package cvxif_instr_pkg;

  localparam int XLEN      = 32;
  localparam int VLenMax   = 8;
  localparam int IdWidth   = 4;
  localparam int VLenWidth = $clog2(VLenMax + 1);
  localparam int IdxWidth  = $clog2(VLenMax);

  typedef logic [VLenWidth-1:0] vlen_t;
  typedef logic [IdxWidth-1:0]  idx_t;

  typedef enum logic [1:0] {
    MV_V_X   = 2'd0,
    ADD_V_X  = 2'd1,
    REDSUM_V = 2'd2
  } custom_vec_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } exec_state_e;

  // Requests longer than the element file are silently truncated to its size.
  function automatic vlen_t clampVlen(input vlen_t v);
    return (v > vlen_t'(VLenMax)) ? vlen_t'(VLenMax) : v;
  endfunction

endpackage

// File: rtl/cvxif_vec_exec_if.sv
// Issue and result channels between the predecoder/core and the execution stage.
interface cvxif_vec_exec_if;
  import cvxif_instr_pkg::*;

  logic                 issue_valid_i;
  logic                 issue_accept_i;
  logic                 issue_ready_o;
  custom_vec_op_e       instr_op_i;
  vlen_t                vlen_i;
  logic [XLEN-1:0]      rs1_i;
  logic [4:0]           rd_i;
  logic [IdWidth-1:0]   id_i;

  logic                 result_valid_o;
  logic                 result_ready_i;
  logic [IdWidth-1:0]   result_id_o;
  logic [4:0]           result_rd_o;
  logic [XLEN-1:0]      result_data_o;
  logic                 result_we_o;

  modport slave (
    input  issue_valid_i, issue_accept_i, instr_op_i, vlen_i, rs1_i, rd_i, id_i,
    input  result_ready_i,
    output issue_ready_o,
    output result_valid_o, result_id_o, result_rd_o, result_data_o, result_we_o
  );

  modport master (
    output issue_valid_i, issue_accept_i, instr_op_i, vlen_i, rs1_i, rd_i, id_i,
    output result_ready_i,
    input  issue_ready_o,
    input  result_valid_o, result_id_o, result_rd_o, result_data_o, result_we_o
  );

endinterface

// File: rtl/cvxif_vec_exec_elem_file.sv
// Vector element file: one read and one write port sharing the element index.
module vec_elem_file
  import cvxif_instr_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  idx_t            i_idx,
  input  logic            i_we,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_rdata
);

  logic [XLEN-1:0] r_elem [VLenMax];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < VLenMax; i++) begin
        r_elem[i] <= '0;
      end
    end else if (i_we) begin
      r_elem[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_elem[i_idx];

endmodule

// File: rtl/cvxif_vec_exec.sv
// Execution stage: walks the element file one element per cycle, then offers one result beat.
module cvxif_vec_exec
  import cvxif_instr_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  cvxif_vec_exec_if.slave bus,
  output logic            busy_o
);

  exec_state_e        r_state;
  exec_state_e        w_nextState;
  custom_vec_op_e     r_op;
  vlen_t              r_vlen;
  idx_t               r_idx;
  logic [XLEN-1:0]    r_rs1;
  logic [XLEN-1:0]    r_acc;
  logic [4:0]         r_rd;
  logic [IdWidth-1:0] r_id;
  logic               r_we;

  logic               w_fire;
  logic               w_issueReady;
  logic               w_resultValid;
  logic               w_busy;
  logic               w_lastElem;
  logic               w_elemWe;
  logic [XLEN-1:0]    w_rdata;
  logic [XLEN-1:0]    w_wdata;
  vlen_t              w_vlenClamped;

  assign w_fire        = bus.issue_valid_i & bus.issue_accept_i & w_issueReady;
  assign w_vlenClamped = clampVlen(bus.vlen_i);
  assign w_lastElem    = (vlen_t'(r_idx) == (r_vlen - vlen_t'(1)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_fire) begin
          w_nextState = (w_vlenClamped != '0) ? ST_EXEC : ST_RESP;
        end
      end
      ST_EXEC: begin
        if (w_lastElem) begin
          w_nextState = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.result_ready_i) begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Handshake outputs come straight from the state register, so leaving RESP
  // never overlaps with a new issue in the same cycle.
  always_comb begin
    w_issueReady  = 1'b0;
    w_resultValid = 1'b0;
    w_busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_issueReady = 1'b1;
        w_busy       = 1'b0;
      end
      ST_EXEC: ;
      ST_RESP: w_resultValid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_elemWe = (r_state == ST_EXEC) && (r_op != REDSUM_V);
    w_wdata  = r_rs1;
    if (r_op == ADD_V_X) begin
      w_wdata = w_rdata + r_rs1;
    end
  end

  // Result fields only move on a fire or while accumulating in EXEC, so they
  // hold steady for as long as the core stalls the RESP beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_op   <= MV_V_X;
      r_vlen <= '0;
      r_idx  <= '0;
      r_rs1  <= '0;
      r_acc  <= '0;
      r_rd   <= '0;
      r_id   <= '0;
      r_we   <= 1'b0;
    end else if (w_fire) begin
      r_op   <= bus.instr_op_i;
      r_vlen <= w_vlenClamped;
      r_idx  <= '0;
      r_rs1  <= bus.rs1_i;
      r_acc  <= '0;
      r_rd   <= bus.rd_i;
      r_id   <= bus.id_i;
      r_we   <= (bus.instr_op_i == REDSUM_V);
    end else if (r_state == ST_EXEC) begin
      r_idx <= r_idx + idx_t'(1);
      if (r_op == REDSUM_V) begin
        r_acc <= r_acc + w_rdata;
      end
    end
  end

  vec_elem_file u_elemFile (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_idx   (r_idx),
    .i_we    (w_elemWe),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  assign bus.issue_ready_o  = w_issueReady;
  assign bus.result_valid_o = w_resultValid;
  assign bus.result_id_o    = r_id;
  assign bus.result_rd_o    = r_rd;
  assign bus.result_data_o  = r_acc;
  assign bus.result_we_o    = r_we;
  assign busy_o             = w_busy;

endmodule

// File: tb/tb_cvxif_vec_exec.sv
// Directed, table-driven bench for cvxif_vec_exec with hand-computed results.
module tb_cvxif_vec_exec;
  import cvxif_instr_pkg::*;

  typedef struct {
    custom_vec_op_e op;
    vlen_t          vlen;
    logic [31:0]    rs1;
    logic [4:0]     rd;
    logic [3:0]     id;
    int             expLat;
    logic [31:0]    expData;
    logic           expWe;
  } vec_t;

  logic clk;
  logic rst;
  logic busy;
  int   checks;
  int   failures;
  vec_t vectors [10];

  cvxif_vec_exec_if bus ();

  cvxif_vec_exec dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (bus),
    .busy_o (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic vec_t mkVec(input custom_vec_op_e op, input vlen_t vlen, input logic [31:0] rs1,
                                 input logic [4:0] rd, input logic [3:0] id, input int expLat,
                                 input logic [31:0] expData, input logic expWe);
    vec_t v;
    v.op = op; v.vlen = vlen; v.rs1 = rs1; v.rd = rd; v.id = id;
    v.expLat = expLat; v.expData = expData; v.expWe = expWe;
    return v;
  endfunction

  // Called at a negedge in IDLE; returns at the negedge after the fire edge.
  task automatic fireIssue(input custom_vec_op_e op, input vlen_t vlen, input logic [31:0] rs1,
                           input logic [4:0] rd, input logic [3:0] id);
    bus.instr_op_i     = op;
    bus.vlen_i         = vlen;
    bus.rs1_i          = rs1;
    bus.rd_i           = rd;
    bus.id_i           = id;
    bus.issue_valid_i  = 1'b1;
    bus.issue_accept_i = 1'b1;
    @(posedge clk);
    #1;
    bus.issue_valid_i  = 1'b0;
    bus.issue_accept_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitValid(input string name, input int expLat);
    int lat;
    lat = 0;
    while (!bus.result_valid_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({name, "_lat"}, 32'(lat), 32'(expLat));
  endtask

  task automatic applyStimulus(input vec_t v, input int n);
    string nm;
    nm = $sformatf("vec%0d", n);
    checkOutput({nm, "_issueReady"}, 32'(bus.issue_ready_o), 32'd1);
    fireIssue(v.op, v.vlen, v.rs1, v.rd, v.id);
    checkOutput({nm, "_busy"}, 32'(busy), 32'd1);
    waitValid(nm, v.expLat);
    checkOutput({nm, "_data"}, bus.result_data_o, v.expData);
    checkOutput({nm, "_we"}, 32'(bus.result_we_o), 32'(v.expWe));
    checkOutput({nm, "_id"}, 32'(bus.result_id_o), 32'(v.id));
    checkOutput({nm, "_rd"}, 32'(bus.result_rd_o), 32'(v.rd));
    bus.result_ready_i = 1'b1;
    @(negedge clk);
    bus.result_ready_i = 1'b0;
    checkOutput({nm, "_validDrop"}, 32'(bus.result_valid_o), 32'd0);
  endtask

  initial begin
    int seenBeat;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.issue_valid_i  = 1'b0;
    bus.issue_accept_i = 1'b0;
    bus.instr_op_i     = MV_V_X;
    bus.vlen_i         = '0;
    bus.rs1_i          = '0;
    bus.rd_i           = '0;
    bus.id_i           = '0;
    bus.result_ready_i = 1'b0;

    // Element contents after each row are tracked by hand in the expected data.
    vectors[0] = mkVec(MV_V_X,   4'd4,  32'h0000_0005, 5'd1,  4'h1, 4, 32'h0,          1'b0);
    vectors[1] = mkVec(REDSUM_V, 4'd4,  32'h0,         5'd2,  4'h2, 4, 32'h0000_0014, 1'b1);
    vectors[2] = mkVec(ADD_V_X,  4'd4,  32'hFFFF_FFFF, 5'd3,  4'h3, 4, 32'h0,          1'b0);
    vectors[3] = mkVec(REDSUM_V, 4'd4,  32'h0,         5'd4,  4'h4, 4, 32'h0000_0010, 1'b1);
    vectors[4] = mkVec(REDSUM_V, 4'd0,  32'h0,         5'd5,  4'h5, 0, 32'h0,          1'b1);
    vectors[5] = mkVec(REDSUM_V, 4'd15, 32'h0,         5'd6,  4'h6, 8, 32'h0000_0010, 1'b1);
    vectors[6] = mkVec(MV_V_X,   4'd2,  32'h8000_0000, 5'd7,  4'h7, 2, 32'h0,          1'b0);
    vectors[7] = mkVec(REDSUM_V, 4'd3,  32'h0,         5'd8,  4'h8, 3, 32'h0000_0004, 1'b1);
    vectors[8] = mkVec(ADD_V_X,  4'd1,  32'h0000_0001, 5'd9,  4'hA, 1, 32'h0,          1'b0);
    vectors[9] = mkVec(REDSUM_V, 4'd8,  32'h0,         5'd31, 4'hF, 8, 32'h0000_0009, 1'b1);

    repeat (2) @(negedge clk);
    checkOutput("rst_issueReady", 32'(bus.issue_ready_o), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_valid", 32'(bus.result_valid_o), 32'd0);
    checkOutput("rst_we", 32'(bus.result_we_o), 32'd0);
    checkOutput("rst_data", bus.result_data_o, 32'd0);
    checkOutput("rst_id", 32'(bus.result_id_o), 32'd0);
    checkOutput("rst_rd", 32'(bus.result_rd_o), 32'd0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vectors[i], i);
    end

    $display("[TB] stalled result beat");
    fireIssue(REDSUM_V, 4'd2, 32'h0, 5'd7, 4'h9);
    waitValid("stall", 2);
    bus.instr_op_i     = MV_V_X;
    bus.vlen_i         = 4'd1;
    bus.id_i           = 4'h5;
    bus.issue_valid_i  = 1'b1;
    bus.issue_accept_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("stall%0d_valid", i), 32'(bus.result_valid_o), 32'd1);
      checkOutput($sformatf("stall%0d_data", i), bus.result_data_o, 32'h0000_0001);
      checkOutput($sformatf("stall%0d_id", i), 32'(bus.result_id_o), 32'h9);
      checkOutput($sformatf("stall%0d_rd", i), 32'(bus.result_rd_o), 32'd7);
      checkOutput($sformatf("stall%0d_we", i), 32'(bus.result_we_o), 32'd1);
      checkOutput($sformatf("stall%0d_issueReady", i), 32'(bus.issue_ready_o), 32'd0);
      @(negedge clk);
    end
    bus.issue_valid_i  = 1'b0;
    bus.issue_accept_i = 1'b0;
    bus.result_ready_i = 1'b1;
    @(negedge clk);
    bus.result_ready_i = 1'b0;
    checkOutput("stall_release_valid", 32'(bus.result_valid_o), 32'd0);

    $display("[TB] offer without accept");
    bus.issue_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("noAccept%0d_busy", i), 32'(busy), 32'd0);
      checkOutput($sformatf("noAccept%0d_id", i), 32'(bus.result_id_o), 32'h9);
    end
    bus.issue_valid_i = 1'b0;

    $display("[TB] reset during EXEC");
    fireIssue(MV_V_X, 4'd8, 32'h0000_1234, 5'd12, 4'h3);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midRst_busy", 32'(busy), 32'd0);
    checkOutput("midRst_issueReady", 32'(bus.issue_ready_o), 32'd1);
    checkOutput("midRst_id", 32'(bus.result_id_o), 32'd0);
    checkOutput("midRst_rd", 32'(bus.result_rd_o), 32'd0);
    #1 rst = 1'b0;
    seenBeat = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.result_valid_o) seenBeat = 1;
    end
    checkOutput("midRst_noBeat", 32'(seenBeat), 32'd0);
    applyStimulus(mkVec(REDSUM_V, 4'd8, 32'h0, 5'd2, 4'hC, 8, 32'h0, 1'b1), 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
